bus_trace_buffer: RTL and testbench
===================================

// Module: bus_trace_buffer
// PURPOSE
//  Captures every completed 68000 bus cycle (address, data, direction, byte strobes) into a
//  small FIFO clocked by CPUCLK. Sits between bus control, which produces DTACK, and the SPI
//  monitor, which pops entries and shifts them out. Captures only while the CPU is running.
// PARAMETERS
//  DEPTH      16  FIFO entries; power of two, 4..64
//  PTR_W      4   log2(DEPTH)
// PORTS
//  CPUCLK_IN   in   1   CPU clock; the only clock
//  RESET_IN    in   1   synchronous, active-high reset
//  RUN_IN      in   1   1 = CPU running; capture enabled
//  AS_IN       in   1   address strobe, active-high
//  WR_IN       in   1   1 = write cycle
//  UDS_IN      in   1   upper data strobe, active-high
//  LDS_IN      in   1   lower data strobe, active-high
//  DTACK_IN    in   1   DTACK from bus control, active-high
//  ADDR_IN     in   24  CPU address bus
//  DATA_IN     in   16  CPU data bus
//  POP_IN      in   1   monitor consumes ENTRY_OUT this cycle
//  CLEAR_IN    in   1   flush FIFO and clear OVERFLOW
//  ENTRY_OUT   out  43  {WR,UDS,LDS,ADDR[23:0],DATA[15:0]}; head entry, first-word-fall-through
//  VALID_OUT   out  1   ENTRY_OUT holds a valid entry (FIFO not empty)
//  COUNT_OUT   out  PTR_W+1  number of stored entries, 0..DEPTH
//  OVERFLOW    out  1   sticky; a capture was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: state IDLE, pointers 0, COUNT_OUT=0, VALID_OUT=0, OVERFLOW=0, ENTRY_OUT=0.
//  Capture FSM, all transitions on the CPUCLK_IN rising edge:
//   IDLE   : AS_IN & RUN_IN -> ACTIVE.
//   ACTIVE : ~AS_IN -> IDLE with no push (aborted cycle).
//            DTACK_IN & (UDS_IN|LDS_IN) -> latch WR, UDS, LDS and ADDR; -> SAMPLE.
//   SAMPLE : latch DATA_IN (read data is stable one clock after DTACK); request push; -> DONE.
//   DONE   : wait for ~AS_IN -> IDLE. Exactly one push per bus cycle; DTACK held over many
//            clocks does not push again.
//  RUN_IN low: the FSM goes to IDLE on the next edge and no push occurs. Captured fields
//   from an unfinished cycle are discarded.
//  Latency: DTACK seen at edge N -> SAMPLE at N+1 -> entry written at N+1 -> VALID_OUT and
//   ENTRY_OUT updated after edge N+2 when the FIFO was empty.
//  FIFO rules:
//   - push & ~full -> write at wptr; wptr increments and wraps mod DEPTH.
//   - push & full & ~POP_IN -> entry dropped; OVERFLOW set; FIFO contents unchanged.
//   - push & full & POP_IN -> both succeed; COUNT_OUT stays DEPTH.
//   - POP_IN & empty -> ignored; no pointer change.
//   - push & pop when non-empty -> COUNT_OUT unchanged; both pointers advance.
//   - CLEAR_IN has priority over push and pop: pointers and COUNT_OUT go to 0, OVERFLOW=0.
//     A push requested in the same cycle is lost. The FSM state is not affected.
//  RESET_IN mid-cycle: the FSM returns to IDLE. If AS_IN is still high when reset releases,
//   that bus cycle is traced only if DTACK_IN has not yet been seen (the FSM re-enters
//   ACTIVE from IDLE).
//  Address field: the full 24 bits as presented; A0 is recorded verbatim with no decoding.
// STRUCTURE
//  Shared include bus_trace_defs.vh: localparams ENTRY_W=43 and field offsets DATA_LSB=0,
//   ADDR_LSB=16, LDS_BIT=40, UDS_BIT=41, WR_BIT=42. The SPI monitor uses the same include.
//  Sub-module trace_fifo (synchronous FWFT FIFO with push, pop, clear, count, full/empty)
//   holds the storage. bus_trace_buffer contains the FSM and the overflow flag.
// TESTING
//  1 Write cycle: ADDR=0x100004, DATA=0xBEEF, WR=1, UDS=LDS=1, DTACK held 3 clocks ->
//    exactly one entry {1,1,1,0x100004,0xBEEF}; VALID_OUT rises 2 edges after DTACK.
//  2 Aborted cycle: AS_IN pulses high 2 clocks with no DTACK -> COUNT_OUT stays 0.
//  3 Fill: 17 byte-read cycles with no pop, DEPTH=16 -> COUNT_OUT=16, OVERFLOW=1, and the
//    head entry is still the first cycle's entry.
//  4 Full with simultaneous push and pop -> COUNT_OUT=16, OVERFLOW stays 0, head advances one.
//  5 Pop while empty, then CLEAR_IN in the same cycle as a push -> COUNT_OUT=0, VALID_OUT=0.
//  6 RUN_IN=0 during cycles, then RESET_IN asserted mid-ACTIVE -> no entries; all outputs at
//    reset values.

Source files
------------

// File: rtl/bus_trace_buffer_pkg.sv
// Shared definitions for the bus trace buffer: entry layout, FIFO sizing and capture FSM states.
// Field offsets match the layout the SPI monitor unpacks.
package bus_trace_buffer_pkg;

  localparam int ENTRY_W  = 43;
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 16;
  localparam int LDS_BIT  = 40;
  localparam int UDS_BIT  = 41;
  localparam int WR_BIT   = 42;

  localparam int DEPTH_DEF = 16;
  localparam int PTR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } capture_state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic        wr,
    input logic        uds,
    input logic        lds,
    input logic [23:0] addr,
    input logic [15:0] data
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[WR_BIT]                 = wr;
    e[UDS_BIT]                = uds;
    e[LDS_BIT]                = lds;
    e[ADDR_LSB +: 24]         = addr;
    e[DATA_LSB +: 16]         = data;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with push, pop, clear and occupancy count.
// The head reads as zero while empty so the output is never stale storage.
module trace_fifo #(
  parameter int W     = 43,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO succeeds only when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/bus_trace_buffer.sv
// Captures each completed 68000 bus cycle into a FWFT trace FIFO read by the SPI monitor.
// Valid/ready: an entry is transferred when VALID_OUT and POP_IN are both high on a CPUCLK_IN edge.
module bus_trace_buffer
  import bus_trace_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic                CPUCLK_IN,
  input  logic                RESET_IN,
  input  logic                RUN_IN,
  input  logic                AS_IN,
  input  logic                WR_IN,
  input  logic                UDS_IN,
  input  logic                LDS_IN,
  input  logic                DTACK_IN,
  input  logic [23:0]         ADDR_IN,
  input  logic [15:0]         DATA_IN,
  input  logic                POP_IN,
  input  logic                CLEAR_IN,
  output logic [ENTRY_W-1:0]  ENTRY_OUT,
  output logic                VALID_OUT,
  output logic [PTR_W:0]      COUNT_OUT,
  output logic                OVERFLOW,
  output capture_state_t      state_dbg
);

  capture_state_t     state;
  logic               wr_q;
  logic               uds_q;
  logic               lds_q;
  logic [23:0]        addr_q;
  logic [ENTRY_W-1:0] entry_q;
  logic               push_req;
  logic               fifo_full;
  logic               fifo_empty;

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      state    <= ST_IDLE;
      wr_q     <= 1'b0;
      uds_q    <= 1'b0;
      lds_q    <= 1'b0;
      addr_q   <= '0;
      entry_q  <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (AS_IN && RUN_IN) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!RUN_IN || !AS_IN) begin
            state <= ST_IDLE;
          end else if (DTACK_IN && (UDS_IN || LDS_IN)) begin
            wr_q   <= WR_IN;
            uds_q  <= UDS_IN;
            lds_q  <= LDS_IN;
            addr_q <= ADDR_IN;
            state  <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // Read data settles one clock after DTACK, so the data bus is taken here.
          if (!RUN_IN) begin
            state <= ST_IDLE;
          end else begin
            entry_q  <= pack_entry(wr_q, uds_q, lds_q, addr_q, DATA_IN);
            push_req <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!RUN_IN || !AS_IN) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN || CLEAR_IN) OVERFLOW <= 1'b0;
    else if (push_req && fifo_full && !POP_IN) OVERFLOW <= 1'b1;
  end

  trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (CPUCLK_IN),
    .rst   (RESET_IN),
    .push  (push_req),
    .pop   (POP_IN),
    .clear (CLEAR_IN),
    .wdata (entry_q),
    .rdata (ENTRY_OUT),
    .count (COUNT_OUT),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign VALID_OUT = ~fifo_empty;
  assign state_dbg = state;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Bench for bus_trace_buffer: table-driven bus cycles plus hand sequences for latency,
// overflow, simultaneous push/pop, clear and reset corners, checked against a queue.
module tb_bus_trace_buffer;
  import bus_trace_buffer_pkg::*;

  logic               clk;
  logic               rst;
  logic               run;
  logic               as_s;
  logic               wr;
  logic               uds;
  logic               lds;
  logic               dtack;
  logic [23:0]        addr;
  logic [15:0]        data;
  logic               pop;
  logic               clear;
  logic [42:0]        entry;
  logic               valid;
  logic [4:0]         count;
  logic               overflow;
  capture_state_t     state_dbg;

  logic [42:0] exp_q[$];
  int total;
  int bad;

  typedef struct {
    logic        wr;
    logic        uds;
    logic        lds;
    logic [23:0] addr;
    logic [15:0] data;
    int          dtack_clks;
    logic        exp_push;
    logic [42:0] exp_entry;
  } vec_t;

  vec_t vecs[6];

  bus_trace_buffer dut (
    .CPUCLK_IN (clk),
    .RESET_IN  (rst),
    .RUN_IN    (run),
    .AS_IN     (as_s),
    .WR_IN     (wr),
    .UDS_IN    (uds),
    .LDS_IN    (lds),
    .DTACK_IN  (dtack),
    .ADDR_IN   (addr),
    .DATA_IN   (data),
    .POP_IN    (pop),
    .CLEAR_IN  (clear),
    .ENTRY_OUT (entry),
    .VALID_OUT (valid),
    .COUNT_OUT (count),
    .OVERFLOW  (overflow),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // drivers
  task automatic bus_cycle(input logic w, input logic u, input logic l,
                           input logic [23:0] a, input logic [15:0] d, input int dclks,
                           input logic pop_at_write, input logic clear_at_write);
    as_s = 1'b1; wr = w; uds = u; lds = l; addr = a; data = d;
    tick();
    dtack = 1'b1;
    repeat (dclks) tick();
    dtack = 1'b0;
    as_s  = 1'b0;
    tick();
    if (pop_at_write) begin
      if (exp_q.size() == 0) check("pop_at_write queue", 64'd0, 64'd1);
      else check("pop_at_write head", 64'(entry), 64'(exp_q.pop_front()));
      pop = 1'b1;
    end
    if (clear_at_write) clear = 1'b1;
    tick();
    pop   = 1'b0;
    clear = 1'b0;
  endtask

  task automatic pop_check(input string name);
    check({name, " valid"}, 64'(valid), 64'd1);
    if (exp_q.size() == 0) check({name, " queue"}, 64'd0, 64'd1);
    else check({name, " entry"}, 64'(entry), 64'(exp_q.pop_front()));
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) pop_check(name);
    check({name, " empty count"}, 64'(count), 64'd0);
    check({name, " empty valid"}, 64'(valid), 64'd0);
  endtask

  initial begin
    logic [42:0] e;
    logic        rw, ru, rl;
    logic [23:0] ra;
    logic [15:0] rd;

    total = 0; bad = 0;
    rst = 1'b1; run = 1'b1; as_s = 1'b0; wr = 1'b0; uds = 1'b0; lds = 1'b0;
    dtack = 1'b0; addr = '0; data = '0; pop = 1'b0; clear = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 24'hFFFFFE, 16'h1234, 1, 1'b1, {1'b1, 1'b1, 1'b1, 24'hFFFFFE, 16'h1234}};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 24'h000001, 16'h00A5, 2, 1'b1, {1'b0, 1'b1, 1'b0, 24'h000001, 16'h00A5}};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 24'h123457, 16'h5A5A, 1, 1'b1, {1'b0, 1'b0, 1'b1, 24'h123457, 16'h5A5A}};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 24'h00ABCD, 16'hFFFF, 2, 1'b0, 43'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 24'h800000, 16'h0000, 4, 1'b1, {1'b1, 1'b0, 1'b1, 24'h800000, 16'h0000}};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 24'h000000, 16'h8001, 1, 1'b1, {1'b0, 1'b1, 1'b1, 24'h000000, 16'h8001}};

    repeat (3) tick();
    rst = 1'b0;
    check("reset count", 64'(count), 64'd0);
    check("reset valid", 64'(valid), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset entry", 64'(entry), 64'd0);
    check("reset state", 64'(state_dbg), 64'(ST_IDLE));

    // Write cycle with DTACK held three clocks: one entry, valid two edges after DTACK.
    as_s = 1'b1; wr = 1'b1; uds = 1'b1; lds = 1'b1; addr = 24'h100004; data = 16'hBEEF;
    tick();
    dtack = 1'b1;
    tick();
    check("t1 valid after N", 64'(valid), 64'd0);
    tick();
    check("t1 valid after N+1", 64'(valid), 64'd0);
    tick();
    check("t1 valid after N+2", 64'(valid), 64'd1);
    check("t1 count after N+2", 64'(count), 64'd1);
    dtack = 1'b0; as_s = 1'b0;
    repeat (3) tick();
    check("t1 single push", 64'(count), 64'd1);
    exp_q.push_back({1'b1, 1'b1, 1'b1, 24'h100004, 16'hBEEF});
    pop_check("t1");

    // Table-driven cycles, queued then drained in order.
    foreach (vecs[i]) begin
      bus_cycle(vecs[i].wr, vecs[i].uds, vecs[i].lds, vecs[i].addr, vecs[i].data,
                vecs[i].dtack_clks, 1'b0, 1'b0);
      if (vecs[i].exp_push) exp_q.push_back(vecs[i].exp_entry);
      check($sformatf("vec%0d count", i), 64'(count), 64'(exp_q.size()));
    end
    drain("vec");

    // Random cycles.
    for (int i = 0; i < 8; i++) begin
      rw = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      rl = ru ? 1'($urandom_range(0, 1)) : 1'b1;
      ra = 24'($urandom_range(0, 32'hFFFFFF));
      rd = 16'($urandom_range(0, 16'hFFFF));
      bus_cycle(rw, ru, rl, ra, rd, int'($urandom_range(1, 3)), 1'b0, 1'b0);
      exp_q.push_back({rw, ru, rl, ra, rd});
    end
    check("rand count", 64'(count), 64'd8);
    drain("rand");

    // Aborted cycle.
    as_s = 1'b1;
    repeat (2) tick();
    as_s = 1'b0;
    repeat (2) tick();
    check("t2 abort count", 64'(count), 64'd0);
    check("t2 abort state", 64'(state_dbg), 64'(ST_IDLE));

    // Fill past full with byte reads.
    for (int i = 0; i < 17; i++) begin
      bus_cycle(1'b0, 1'b0, 1'b1, 24'(2 * i + 1), 16'(16'h0100 + i), 1, 1'b0, 1'b0);
      e = {1'b0, 1'b0, 1'b1, 24'(2 * i + 1), 16'(16'h0100 + i)};
      if (i < 16) exp_q.push_back(e);
      if (i == 15) check("t3 overflow at 16", 64'(overflow), 64'd0);
    end
    check("t3 count", 64'(count), 64'd16);
    check("t3 overflow", 64'(overflow), 64'd1);
    check("t3 head", 64'(entry), 64'(exp_q[0]));

    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    check("clear count", 64'(count), 64'd0);
    check("clear overflow", 64'(overflow), 64'd0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 16; i++) begin
      bus_cycle(1'b1, 1'b1, 1'b0, 24'(24'h200000 + 2 * i), 16'(16'hC000 + i), 1, 1'b0, 1'b0);
      exp_q.push_back({1'b1, 1'b1, 1'b0, 24'(24'h200000 + 2 * i), 16'(16'hC000 + i)});
    end
    check("t4 full count", 64'(count), 64'd16);
    bus_cycle(1'b0, 1'b1, 1'b1, 24'hABCDEF, 16'h7777, 1, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 24'hABCDEF, 16'h7777});
    check("t4 count", 64'(count), 64'd16);
    check("t4 overflow", 64'(overflow), 64'd0);
    check("t4 head advanced", 64'(entry), 64'(exp_q[0]));
    drain("t4");

    // Pop while empty, then clear coinciding with a push.
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("t5 pop empty count", 64'(count), 64'd0);
    bus_cycle(1'b1, 1'b1, 1'b1, 24'h000010, 16'h4242, 1, 1'b0, 1'b1);
    tick();
    check("t5 clear count", 64'(count), 64'd0);
    check("t5 clear valid", 64'(valid), 64'd0);
    check("t5 clear overflow", 64'(overflow), 64'd0);

    // Stopped CPU, then reset in the middle of an active cycle.
    run = 1'b0;
    bus_cycle(1'b1, 1'b1, 1'b1, 24'h000020, 16'h1111, 2, 1'b0, 1'b0);
    bus_cycle(1'b0, 1'b0, 1'b1, 24'h000021, 16'h2222, 1, 1'b0, 1'b0);
    check("t6 run low count", 64'(count), 64'd0);
    run = 1'b1;
    as_s = 1'b1; wr = 1'b1; uds = 1'b1; lds = 1'b1; addr = 24'h000030; data = 16'h3333;
    tick();
    check("t6 state active", 64'(state_dbg), 64'(ST_ACTIVE));
    rst = 1'b1;
    tick();
    as_s = 1'b0; rst = 1'b0;
    tick();
    check("t6 count", 64'(count), 64'd0);
    check("t6 valid", 64'(valid), 64'd0);
    check("t6 overflow", 64'(overflow), 64'd0);
    check("t6 entry", 64'(entry), 64'd0);
    check("t6 state", 64'(state_dbg), 64'(ST_IDLE));

    // Reset released with AS still high and DTACK not yet seen: cycle is traced.
    as_s = 1'b1; wr = 1'b0; uds = 1'b1; lds = 1'b0; addr = 24'h0A0A0B; data = 16'h5150;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("t7 reentered active", 64'(state_dbg), 64'(ST_ACTIVE));
    dtack = 1'b1;
    tick();
    dtack = 1'b0; as_s = 1'b0;
    repeat (2) tick();
    exp_q.push_back({1'b0, 1'b1, 1'b0, 24'h0A0A0B, 16'h5150});
    check("t7 count", 64'(count), 64'd1);
    drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
